// File: rtl/regfile_wb.sv
// Architectural register file at the write-back end of the decode interface.
// Two combinational read ports with same-cycle write bypass; $r0 is hard-wired to zero.
module regfile_wb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB,
    output logic [15:0]           write_count
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    // Entry 0 is never written and never read, so it carries no state.
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic write_live;
    logic commit;
    logic bypass_a;
    logic bypass_b;
    logic [DATA_WIDTH-1:0] array_a;
    logic [DATA_WIDTH-1:0] array_b;

    assign write_live = ctrl_writeEnable && !ctrl_reset;
    assign commit     = write_live && (ctrl_writeReg != '0);

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (commit && (ctrl_writeReg == ADDR_WIDTH'(i))) begin
                    regs[i] <= data_writeReg;
                end
            end
        end
    end

    assign regs[0] = '0;

    // Saturating commit counter; holds at all-ones instead of wrapping.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            write_count <= '0;
        end else if (commit && (write_count != 16'hFFFF)) begin
            write_count <= write_count + 16'd1;
        end
    end

    always_comb begin
        array_a = '0;
        array_b = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (ctrl_readRegA == ADDR_WIDTH'(i)) begin
                array_a = regs[i];
            end
            if (ctrl_readRegB == ADDR_WIDTH'(i)) begin
                array_b = regs[i];
            end
        end
    end

    assign bypass_a = write_live && (ctrl_writeReg == ctrl_readRegA);
    assign bypass_b = write_live && (ctrl_writeReg == ctrl_readRegB);

    // Index 0 takes priority over bypass so a discarded write to $r0 never leaks out.
    always_comb begin
        data_readRegA = array_a;
        if (ctrl_readRegA == '0) begin
            data_readRegA = '0;
        end else if (bypass_a) begin
            data_readRegA = data_writeReg;
        end
    end

    always_comb begin
        data_readRegB = array_b;
        if (ctrl_readRegB == '0) begin
            data_readRegB = '0;
        end else if (bypass_b) begin
            data_readRegB = data_writeReg;
        end
    end

endmodule
